// File: rtl/ber_counter.sv
// ber_counter: sweeps candidate delays of the PRBS reference against the sliced symbol sign, locks on the fewest-error delay, then counts errors/bits (clk, i_reset, i_en_rx, i_en_rate1, i_rx_sym, i_ref_bit, i_resync -> o_locked, o_latency, o_err_count, o_bit_count)
module ber_counter #(
    parameter int NBT_IN   = 12,
    parameter int DEPTH    = 511,
    parameter int NB_DELAY = 9,
    parameter int WINDOW   = 511,
    parameter int NB_WIN   = 10,
    parameter int NB_CNT   = 64
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_en_rx,
    input  logic                i_en_rate1,
    input  logic [NBT_IN-1:0]   i_rx_sym,
    input  logic                i_ref_bit,
    input  logic                i_resync,
    output logic                o_locked,
    output logic [NB_DELAY-1:0] o_latency,
    output logic [NB_CNT-1:0]   o_err_count,
    output logic [NB_CNT-1:0]   o_bit_count
);
    typedef enum logic {SEARCH, LOCKED} state_t;
    state_t state, state_n;
    logic [DEPTH-1:0] sr, ref_vec;
    logic [NB_DELAY-1:0] cur_delay, best_delay, best_delay_n, delay;
    logic [NB_WIN-1:0] win_cnt, err_win, best_err, total;
    logic strobe, err, win_end, better;
    logic unused_sym_bits;
    assign unused_sym_bits = ^i_rx_sym[NBT_IN-2:0];
    assign o_locked = state == LOCKED;
    always_comb begin
        strobe = i_en_rx && i_en_rate1;
        ref_vec = {sr[DEPTH-2:0], i_ref_bit};
        delay = state == LOCKED ? best_delay : cur_delay;
        err = i_rx_sym[NBT_IN-1] ^ ref_vec[delay];
        win_end = win_cnt == NB_WIN'(WINDOW - 1);
        total = err_win + NB_WIN'(err);
        better = total < best_err;
        best_delay_n = better ? cur_delay : best_delay;
        state_n = (state == SEARCH && strobe && win_end && cur_delay == NB_DELAY'(DEPTH - 1)) ? LOCKED : state;
    end
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sr          <= '0;
            state       <= SEARCH;
            cur_delay   <= '0;
            win_cnt     <= '0;
            err_win     <= '0;
            best_err    <= '1;
            best_delay  <= '0;
            o_latency   <= '0;
            o_err_count <= '0;
            o_bit_count <= '0;
        end else if (i_resync) begin
            state       <= SEARCH;
            cur_delay   <= '0;
            win_cnt     <= '0;
            err_win     <= '0;
            best_err    <= '1;
            best_delay  <= '0;
            o_latency   <= '0;
            o_err_count <= '0;
            o_bit_count <= '0;
        end else if (strobe) begin
            sr    <= ref_vec;
            state <= state_n;
            if (state == SEARCH) begin
                win_cnt <= win_end ? '0 : win_cnt + 1'b1;
                err_win <= win_end ? '0 : total;
                if (win_end) begin
                    best_err   <= better ? total : best_err;
                    best_delay <= best_delay_n;
                    cur_delay  <= state_n == LOCKED ? cur_delay : cur_delay + 1'b1;
                    o_latency  <= state_n == LOCKED ? best_delay_n : o_latency;
                end
            end else begin
                // each counter saturates on its own
                o_bit_count <= o_bit_count + NB_CNT'(!(&o_bit_count));
                o_err_count <= o_err_count + NB_CNT'(err && !(&o_err_count));
            end
        end
    end
endmodule

// File: tb/tb_ber_counter.sv
// tb_ber_counter: scoreboard bench for ber_counter with a delay-histogram reference model
module tb_ber_counter;
    localparam int DEPTH = 16, WINDOW = 32, NB_DELAY = 4, NB_WIN = 6, NBT = 12;
    logic clk = 1'b0;
    logic i_reset = 1'b0, i_en_rx = 1'b0, i_en_rate1 = 1'b0, i_ref_bit = 1'b0, i_resync = 1'b0;
    logic [NBT-1:0] i_rx_sym = '0;
    logic locked_a, locked_b;
    logic [NB_DELAY-1:0] lat_a, lat_b;
    logic [15:0] err_a, bit_a;
    logic [3:0] err_b, bit_b;
    always #5 clk = ~clk;
    ber_counter #(.NBT_IN(NBT), .DEPTH(DEPTH), .NB_DELAY(NB_DELAY), .WINDOW(WINDOW), .NB_WIN(NB_WIN), .NB_CNT(16)) dut (
        .clk(clk), .i_reset(i_reset), .i_en_rx(i_en_rx), .i_en_rate1(i_en_rate1), .i_rx_sym(i_rx_sym),
        .i_ref_bit(i_ref_bit), .i_resync(i_resync), .o_locked(locked_a), .o_latency(lat_a),
        .o_err_count(err_a), .o_bit_count(bit_a));
    ber_counter #(.NBT_IN(NBT), .DEPTH(DEPTH), .NB_DELAY(NB_DELAY), .WINDOW(WINDOW), .NB_WIN(NB_WIN), .NB_CNT(4)) dut_s (
        .clk(clk), .i_reset(i_reset), .i_en_rx(i_en_rx), .i_en_rate1(i_en_rate1), .i_rx_sym(i_rx_sym),
        .i_ref_bit(i_ref_bit), .i_resync(i_resync), .o_locked(locked_b), .o_latency(lat_b),
        .o_err_count(err_b), .o_bit_count(bit_b));
    typedef struct {bit locked; int lat; longint bits; longint errs;} exp_t;
    exp_t q[$];
    exp_t cur;
    int tests = 0, fails = 0;
    bit started = 0, ev = 0;
    bit hist[$];
    int m_k, m_lat;
    int m_errs[DEPTH];
    bit m_locked;
    longint m_bit, m_err;
    bit tx[$];
    bit [8:0] lfsr = 9'h1FF;
    bit zero_mode = 0, rand_mode = 0;
    int dly = 5;
    function automatic void chk(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction
    function automatic longint sat(longint v, int w);
        longint mx = (longint'(1) << w) - 1;
        return v > mx ? mx : v;
    endfunction
    function automatic void m_clear(bit full);
        m_k = 0; m_locked = 0; m_lat = 0; m_bit = 0; m_err = 0;
        foreach (m_errs[i]) m_errs[i] = 0;
        if (full) hist.delete();
    endfunction
    function automatic exp_t m_exp();
        exp_t e;
        e.locked = m_locked; e.lat = m_lat; e.bits = m_bit; e.errs = m_err;
        return e;
    endfunction
    // errors are tallied per candidate delay window; lock picks the lowest count, earliest delay on ties
    function automatic void m_strobe(bit rx, bit rf);
        int d = m_locked ? m_lat : m_k / WINDOW;
        bit r = d == 0 ? rf : (hist.size() >= d ? hist[hist.size() - d] : 1'b0);
        bit e = rx ^ r;
        if (!m_locked) begin
            m_errs[d] += int'(e);
            m_k++;
            if (m_k == DEPTH * WINDOW) begin
                m_locked = 1;
                m_lat = 0;
                for (int i = 1; i < DEPTH; i++) if (m_errs[i] < m_errs[m_lat]) m_lat = i;
            end
        end else begin
            m_bit++;
            m_err += longint'(e);
        end
        hist.push_back(rf);
        if (hist.size() > DEPTH) void'(hist.pop_front());
    endfunction
    function automatic bit prbs();
        bit b = lfsr[8] ^ lfsr[4];
        lfsr = {lfsr[7:0], b};
        return b;
    endfunction
    function automatic void cmp_out(string tag);
        chk({tag, "_locked_a"}, locked_a, cur.locked);
        chk({tag, "_lat_a"}, lat_a, cur.lat);
        chk({tag, "_bits_a"}, bit_a, sat(cur.bits, 16));
        chk({tag, "_errs_a"}, err_a, sat(cur.errs, 16));
        chk({tag, "_locked_b"}, locked_b, cur.locked);
        chk({tag, "_lat_b"}, lat_b, cur.lat);
        chk({tag, "_bits_b"}, bit_b, sat(cur.bits, 4));
        chk({tag, "_errs_b"}, err_b, sat(cur.errs, 4));
    endfunction
    always @(posedge clk) ev <= !i_reset && (i_resync || (i_en_rx && i_en_rate1));
    always @(negedge clk) begin
        if (started && !i_reset) begin
            if (ev) begin
                if (q.size() == 0) chk("sb_underflow", q.size(), 1);
                else cur = q.pop_front();
            end
            cmp_out("sb");
        end
    end
    task automatic step(input bit en, input bit rate, input bit rs, input bit flip);
        bit rf, rx;
        @(negedge clk);
        i_en_rx = en; i_en_rate1 = rate; i_resync = rs;
        if (en && rate && !rs) begin
            rf = zero_mode ? 1'b0 : (rand_mode ? 1'($urandom) : prbs());
            rx = zero_mode ? 1'b0 : (dly == 0 ? rf : (tx.size() >= dly ? tx[tx.size() - dly] : 1'b0));
            rx ^= flip;
            tx.push_back(rf);
            if (tx.size() > 32) void'(tx.pop_front());
            i_ref_bit = rf;
            i_rx_sym = {rx, (NBT-1)'($urandom)};
            m_strobe(rx, rf);
            q.push_back(m_exp());
        end else begin
            i_ref_bit = 1'($urandom);
            i_rx_sym = NBT'($urandom);
            if (rs) begin
                m_clear(0);
                q.push_back(m_exp());
            end
        end
    endtask
    task automatic strobe(input int gap, input bit flip);
        step(1, 1, 0, flip);
        repeat (gap - 1) step(1, 0, 0, 0);
    endtask
    task automatic strobes(input int n);
        repeat (n) strobe(4, 0);
    endtask
    task automatic areset();
        step(1, 0, 0, 0);
        @(negedge clk);
        #2 i_reset = 1'b1;
        #1;
        m_clear(1);
        q.delete();
        cur = m_exp();
        cmp_out("async_rst");
        @(negedge clk);
        i_reset = 1'b0;
    endtask
    initial begin
        m_clear(1);
        cur = m_exp();
        #1 i_reset = 1'b1;
        repeat (3) @(negedge clk);
        cmp_out("reset");
        i_reset = 1'b0;
        started = 1;
        strobes(250);
        repeat (200) step(0, 1'($urandom), 0, 0);
        strobes(261);
        chk("prelock_locked", locked_a, 0);
        strobes(1);
        chk("lock_locked", locked_a, 1);
        chk("lock_latency", lat_a, 5);
        strobes(1000);
        chk("count_bits", bit_a, 1000);
        chk("count_errs", err_a, 0);
        chk("sat_bits_zero_err", bit_b, 15);
        repeat (3) begin
            strobes(5);
            strobe(4, 1);
        end
        chk("flip_errs", err_a, 3);
        chk("flip_bits", bit_a, 1018);
        chk("flip_errs_b", err_b, 3);
        strobes(299);
        areset();
        strobes(512);
        chk("relock_latency", lat_a, 5);
        chk("relock_locked", locked_a, 1);
        strobes(10);
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        chk("resync_locked", locked_a, 0);
        chk("resync_bits", bit_a, 0);
        chk("resync_lat", lat_a, 0);
        strobes(511);
        chk("resync_prelock", locked_a, 0);
        strobes(1);
        chk("resync_relock_lat", lat_a, 5);
        chk("resync_relock_locked", locked_a, 1);
        areset();
        zero_mode = 1;
        strobes(512);
        chk("tie_latency", lat_a, 0);
        chk("tie_locked", locked_a, 1);
        repeat (20) strobe(2, 1);
        chk("wrong_errs_a", err_a, 20);
        chk("sat_bits_b", bit_b, 15);
        chk("sat_errs_b", err_b, 15);
        zero_mode = 0;
        areset();
        rand_mode = 1;
        dly = $urandom_range(1, DEPTH - 1);
        for (int i = 0; i < 820; i++) begin
            if (i == 100) begin
                step(1, 1, 1, 0);
                step(1, 0, 0, 0);
            end
            if ($urandom_range(0, 19) == 0) repeat ($urandom_range(1, 6)) step(0, 1, 0, 0);
            strobe($urandom_range(1, 4), $urandom_range(0, 7) == 0);
        end
        repeat (3) step(1, 0, 0, 0);
        chk("sb_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ber_counter.md
Name: ber_counter

Overview:
- Per-channel bit-error-rate checker placed directly downstream of the equalizer/slicer. One instance each for I and Q.
- Takes the recovered symbol at the symbol-rate strobe and the local transmit PRBS reference bit.
- Searches for the channel latency by sweeping candidate delays, then locks and accumulates error and bit counts for readback over the uBlaze register path.

Parameters:
- NBT_IN, 12: width of the equalized/sliced symbol input (S(NBT_IN, NBF_IN) format; only the sign bit is used).
- DEPTH, 511: number of candidate delays, equal to the reference shift-register length.
- NB_DELAY, 9: width of delay indices; must satisfy 2^NB_DELAY >= DEPTH.
- WINDOW, 511: symbols per search window at each candidate delay.
- NB_WIN, 10: error/window counter width; must satisfy 2^NB_WIN > WINDOW.
- NB_CNT, 64: width of the accumulated error and bit counters.

Ports:
- clk, in, 1: system clock.
- i_reset, in, 1: asynchronous, active-high reset.
- i_en_rx, in, 1: global receive enable; when low, all state is frozen.
- i_en_rate1, in, 1: symbol-rate strobe. All updates occur only on cycles with i_en_rx && i_en_rate1 (a "strobe").
- i_rx_sym, in, NBT_IN: sliced/equalized symbol; rx_bit = i_rx_sym[NBT_IN-1].
- i_ref_bit, in, 1: TX PRBS bit for this strobe. Mapping: 1 = negative symbol, 0 = positive symbol.
- i_resync, in, 1: synchronous pulse; restarts the search.
- o_locked, out, 1: 1 in the LOCKED state.
- o_latency, out, NB_DELAY: selected delay; valid when o_locked = 1.
- o_err_count, out, NB_CNT: accumulated bit errors since lock.
- o_bit_count, out, NB_CNT: accumulated compared bits since lock.

Behaviour:
- Reference buffer
  - sr[DEPTH-1:0] is a shift register; sr[0] holds the newest bit.
  - ref_vec = {sr[DEPTH-2:0], i_ref_bit}, so delay 0 compares against the current strobe's reference bit.
  - On each strobe, sr shifts in i_ref_bit.
  - Error bit: err = rx_bit XOR ref_vec[delay], where delay = cur_delay in SEARCH and best_delay in LOCKED.
- FSM states: SEARCH, LOCKED.
- Reset (async) and i_resync (sync, highest priority after reset) both force:
  - state = SEARCH, cur_delay = 0, win_cnt = 0, err_win = 0;
  - best_err = all-ones, best_delay = 0;
  - o_locked = 0, o_latency = 0, o_err_count = 0, o_bit_count = 0.
  - Reset additionally clears sr. i_resync does not clear sr.
- SEARCH, on each strobe:
  - win_cnt++ and err_win += err.
  - When win_cnt == WINDOW-1, compute total = err_win + err.
    - If total < best_err (strict), then best_err = total and best_delay = cur_delay. On a tie, the smaller delay is kept.
    - If cur_delay == DEPTH-1, go to LOCKED, using the post-update best_delay. Otherwise cur_delay++.
    - win_cnt = 0, err_win = 0.
  - Search duration is exactly DEPTH*WINDOW strobes.
- LOCKED, on each strobe:
  - o_bit_count += 1 and o_err_count += err.
  - Both counters saturate at 2^NB_CNT-1 independently. A saturated bit count does not stop error counting.
  - o_latency = best_delay, registered and updated on the cycle LOCKED is entered.
- The transition strobe into LOCKED is itself not counted. Counting starts on the next strobe.
- Strobe and i_resync in the same cycle: i_resync wins and the strobe is discarded, including the sr shift.
- Between strobes, or with i_en_rx low, there is no state change. Outputs are registered and hold their values.
- Latency: every counter and flag reflects a strobe one clk after that strobe.

Test Plan:
- DEPTH=16, WINDOW=32; rx_bit = PRBS9 delayed by 5 strobes; strobe every 4 clks -> o_locked rises 1 clk after strobe 512, o_latency=5; after 1000 further strobes, o_bit_count=1000, o_err_count=0.
- Same setup, after lock flip rx_bit on 3 separate strobes -> o_err_count=3, o_bit_count matches the strobe count.
- Same setup with i_en_rx held low for 200 clks mid-search -> lock occurs exactly 512 strobes after reset, o_latency=5 (no strobes lost or added).
- Assert i_reset asynchronously at strobe 300, then i_resync after lock -> all outputs 0 within the reset cycle and 1 clk after i_resync respectively; re-lock again takes 512 strobes, o_latency=5.
- Constant rx_bit=0, ref=all-zeros -> every delay gives 0 errors (tie) -> o_latency=0.
- NB_CNT=4; locked with always-wrong rx -> o_bit_count and o_err_count both stop at 15 after 15 strobes and hold.
